matrix_stream_loader: RTL and testbench
=======================================

Name: matrix_stream_loader

Overview:
Upstream feeder for parallel_matrix_multiplier. Accepts one valid/ready stream of 32-bit words: all of matrix A in row-major order, then all of matrix B. Converts each word into an indexed write strobe (a_in/a_i/a_j/a_we or b_in/b_i/b_j/b_we), then pulses start and holds off the stream until the multiplier reports done.

Parameters:
n, 10, matrix dimension (n x n); must match the multiplier's n
n_len, $clog2(n), index width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
s_data  in  32  stream word
s_valid  in  1  s_data valid
s_ready  out  1  loader can accept a word this cycle
s_last  in  1  marks the final word of B
a_in  out  32  A element data
a_i  out  n_len  A row index
a_j  out  n_len  A column index
a_we  out  1  A write strobe, one-cycle pulse
b_in  out  32  B element data
b_i  out  n_len  B row index
b_j  out  n_len  B column index
b_we  out  1  B write strobe, one-cycle pulse
start  out  1  multiplier start, one-cycle pulse
done  in  1  multiplier done (level)
busy  out  1  high in START or WAIT_DONE
err  out  1  sticky s_last framing error

Behaviour:
- Reset (rst=0, async): state=LOAD_A; row=col=0; phase=CAPTURE. All outputs 0 except s_ready, which is 1 once rst=1. Clears err. Reset mid-load or mid-compute discards the partial pair; the next accepted word goes to A(0,0).
- States: LOAD_A, LOAD_B, START, WAIT_DONE. Each LOAD state alternates two phases, CAPTURE and STROBE.
- CAPTURE: s_ready=1. Accept occurs when s_valid && s_ready in cycle T. At the end of T, register s_data into a_in and b_in (same register) and {row,col} into a_i/a_j and b_i/b_j. Go to STROBE.
- STROBE: cycle T+1. s_ready=0. a_we=1 in LOAD_A, b_we=1 in LOAD_B. Data and indices are stable from T+1 through at least T+2, so an edge-triggered write on the rising edge of the strobe is safe. Return to CAPTURE.
- Throughput: at most 1 word per 2 cycles. If s_valid=0 in CAPTURE, indices, data and strobes hold; no strobe is issued.
- Index advance, after each STROBE: col+1. If col==n-1, col wraps to 0 and row+1.
  - After the STROBE of (n-1,n-1) in LOAD_A: row=col=0, go to LOAD_B.
  - After the STROBE of (n-1,n-1) in LOAD_B: go to START.
- START: one cycle, start=1, s_ready=0. Then WAIT_DONE.
- WAIT_DONE: s_ready=0. A register done_q tracks done. Exit on a rising edge only (done=1 && done_q=0). A done level left high from the previous run must not retrigger. On that edge, next state is LOAD_A with row=col=0.
- s_last check, evaluated on each accepted word:
  - err is set if s_last=1 on any word other than B(n-1,n-1).
  - err is set if s_last=0 on B(n-1,n-1).
  - err stays set until reset. Loading continues; the counters alone delimit matrices.
- a_i/a_j/b_i/b_j never exceed n-1. For non-power-of-2 n, the counters wrap at n, not 2^n_len.
- busy = (state==START || state==WAIT_DONE).

Decomposition:
- Shared package matrix_mul_pkg:
  - state encoding constants (LOAD_A=0, LOAD_B=1, START=2, WAIT_DONE=3)
  - default N=10
  - DATA_W=32
  - function computing n_len
- One sub-module: matrix_index_counter (params n, n_len). Inputs: clk, rst, clr, inc. Outputs: row, col, at_last (row==col==n-1). Wraps as above. Instantiated once and cleared on each A->B transition and on done.

Test Plan:
- Reset, n=2: after rst deasserts, s_ready=1; a_we=b_we=start=busy=err=0; all indices 0.
- n=2, stream words 1..8 with s_valid held high and s_last on word 8:
  - a_we pulses with (a_i,a_j,a_in) = (0,0,1), (0,1,2), (1,0,3), (1,1,4); pulses are 2 cycles apart.
  - b_we pulses likewise with values 5..8.
  - start is high for exactly 1 cycle, 1 cycle after the last b_we.
  - err=0.
- Back-pressure, n=2: insert 3 idle cycles between words 2 and 3 → no strobes during the gap; indices stay at (0,1); word 3 lands at A(1,0).
- Done handshake: done held high from the previous run, then low for 10 cycles, then high → busy=1 and s_ready=0 throughout. One cycle after the rising edge, s_ready=1 and the next word lands at A(0,0). A constant-high done never releases.
- Framing, n=2: s_last on word 3 → err=1 from the cycle after the accept and stays 1; a second run with s_last missing on word 8 also sets err. Writes are unaffected in both cases.
- Reset mid-operation, n=3: assert rst after 12 accepted words (inside LOAD_B) → outputs clear immediately. After release, the next word produces a_we at A(0,0) with its data.

Source files
------------

// File: rtl/matrix_mul_pkg.sv
// Shared types and constants for the matrix multiplier feed path.
// Holds the FSM state/phase encodings, data width and index-width helper.
package matrix_mul_pkg;

    localparam int N_DEFAULT = 10;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        LOAD_A    = 2'd0,
        LOAD_B    = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef enum logic {
        CAPTURE = 1'b0,
        STROBE  = 1'b1
    } phase_t;

    // A 1x1 or 2x2 matrix still needs a one-bit index.
    function automatic int calc_n_len(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over an n x n matrix.
// Wraps at n rather than at the power of two, so indices never exceed n-1.
module matrix_index_counter
    import matrix_mul_pkg::*;
#(
    parameter int n     = N_DEFAULT,
    parameter int n_len = calc_n_len(n)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [n_len-1:0] row,
    output logic [n_len-1:0] col,
    output logic             at_last
);

    localparam logic [n_len-1:0] LAST = n_len'(n - 1);

    logic [n_len-1:0] r_row;
    logic [n_len-1:0] r_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (r_col == LAST) begin
                r_col <= '0;
                r_row <= (r_row == LAST) ? '0 : r_row + n_len'(1);
            end else begin
                r_col <= r_col + n_len'(1);
            end
        end
    end

    assign row     = r_row;
    assign col     = r_col;
    assign at_last = (r_row == LAST) && (r_col == LAST);

endmodule

// File: rtl/matrix_stream_loader.sv
// Turns a word stream (A then B, row-major) into indexed write strobes,
// then fires start and blocks the stream until the multiplier's done rises.
module matrix_stream_loader
    import matrix_mul_pkg::*;
#(
    parameter int n     = N_DEFAULT,
    parameter int n_len = calc_n_len(n)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [DATA_W-1:0] a_in,
    output logic [n_len-1:0]  a_i,
    output logic [n_len-1:0]  a_j,
    output logic              a_we,
    output logic [DATA_W-1:0] b_in,
    output logic [n_len-1:0]  b_i,
    output logic [n_len-1:0]  b_j,
    output logic              b_we,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic              err
);

    state_t            r_state;
    phase_t            r_phase;
    logic              r_done_q;
    logic [DATA_W-1:0] r_data;
    logic [n_len-1:0]  r_i;
    logic [n_len-1:0]  r_j;
    logic              r_a_we;
    logic              r_b_we;
    logic              r_start;
    logic              r_err;

    logic [n_len-1:0]  w_row;
    logic [n_len-1:0]  w_col;
    logic              w_at_last;
    logic              w_in_load;
    logic              w_accept;
    logic              w_inc;
    logic              w_done_rise;
    logic              w_clr;
    logic              w_last_expected;

    assign w_in_load       = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_accept        = w_in_load && (r_phase == CAPTURE) && s_valid;
    assign w_inc           = w_in_load && (r_phase == STROBE);
    assign w_done_rise     = (r_state == WAIT_DONE) && done && !r_done_q;
    assign w_clr           = (w_inc && w_at_last && (r_state == LOAD_A)) || w_done_rise;
    assign w_last_expected = (r_state == LOAD_B) && w_at_last;

    matrix_index_counter #(
        .n     (n),
        .n_len (n_len)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .inc     (w_inc),
        .row     (w_row),
        .col     (w_col),
        .at_last (w_at_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= LOAD_A;
            r_phase  <= CAPTURE;
            r_done_q <= 1'b0;
            r_data   <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_a_we   <= 1'b0;
            r_b_we   <= 1'b0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // done_q follows done every cycle so a level held over from the
            // previous run is already "seen" when WAIT_DONE is entered.
            r_done_q <= done;
            r_a_we   <= 1'b0;
            r_b_we   <= 1'b0;
            r_start  <= 1'b0;
            case (r_state)
                LOAD_A, LOAD_B: begin
                    if (r_phase == CAPTURE) begin
                        if (w_accept) begin
                            r_data  <= s_data;
                            r_i     <= w_row;
                            r_j     <= w_col;
                            r_a_we  <= (r_state == LOAD_A);
                            r_b_we  <= (r_state == LOAD_B);
                            r_phase <= STROBE;
                            if (s_last != w_last_expected) begin
                                r_err <= 1'b1;
                            end
                        end
                    end else begin
                        r_phase <= CAPTURE;
                        if (w_at_last) begin
                            if (r_state == LOAD_A) begin
                                r_state <= LOAD_B;
                            end else begin
                                r_state <= START;
                                r_start <= 1'b1;
                            end
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (w_done_rise) begin
                        r_state <= LOAD_A;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

    assign s_ready = rst && w_in_load && (r_phase == CAPTURE);
    assign a_in    = r_data;
    assign b_in    = r_data;
    assign a_i     = r_i;
    assign a_j     = r_j;
    assign b_i     = r_i;
    assign b_j     = r_j;
    assign a_we    = r_a_we;
    assign b_we    = r_b_we;
    assign start   = r_start;
    assign busy    = (r_state == START) || (r_state == WAIT_DONE);
    assign err     = r_err;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench: a 2x2 loader and a 3x3 loader share the stream inputs,
// each held in reset while the other is exercised.
module tb_matrix_stream_loader;

    typedef struct {
        int          kind;   // 0 = A write, 1 = B write, 2 = start
        int          i;
        int          j;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst2 = 1'b0;
    logic        rst3 = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        done = 1'b0;

    logic        s_ready2, a_we2, b_we2, start2, busy2, err2;
    logic [31:0] a_in2, b_in2;
    logic [0:0]  a_i2, a_j2, b_i2, b_j2;

    logic        s_ready3, a_we3, b_we3, start3, busy3, err3;
    logic [31:0] a_in3, b_in3;
    logic [1:0]  a_i3, a_j3, b_i3, b_j3;

    exp_t q2[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc2 = 0;
    int   last_b_cyc2 = 0;
    logic prev_start2 = 1'b0;

    always #5 clk = ~clk;

    matrix_stream_loader #(.n(2)) u_dut2 (
        .clk(clk), .rst(rst2), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
        .s_last(s_last), .a_in(a_in2), .a_i(a_i2), .a_j(a_j2), .a_we(a_we2),
        .b_in(b_in2), .b_i(b_i2), .b_j(b_j2), .b_we(b_we2), .start(start2),
        .done(done), .busy(busy2), .err(err2)
    );

    matrix_stream_loader #(.n(3)) u_dut3 (
        .clk(clk), .rst(rst3), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready3),
        .s_last(s_last), .a_in(a_in3), .a_i(a_i3), .a_j(a_j3), .a_we(a_we3),
        .b_in(b_in3), .b_i(b_i3), .b_j(b_j3), .b_we(b_we3), .start(start3),
        .done(done), .busy(busy3), .err(err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic ev(input int inst, input int kind, input int i, input int j, input logic [31:0] d);
        exp_t e;
        n_cmp++;
        if ((inst == 2 && q2.size() == 0) || (inst == 3 && q3.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_event inst%0d: got kind %0d (%0d,%0d) data %0h, required none",
                     inst, kind, i, j, d);
            return;
        end
        if (inst == 2) e = q2.pop_front();
        else           e = q3.pop_front();
        if (e.kind != kind || e.i != i || e.j != j || e.d != d) begin
            n_err++;
            $display("FAIL event inst%0d: got kind %0d (%0d,%0d) data %0h, required kind %0d (%0d,%0d) data %0h",
                     inst, kind, i, j, d, e.kind, e.i, e.j, e.d);
        end else begin
            $display("inst%0d kind %0d (%0d,%0d) data %0h ok", inst, kind, i, j, d);
        end
    endtask

    // Monitor: every strobe or start pulse pops and compares the next expectation.
    initial begin
        forever begin
            @(negedge clk);
            cyc2++;
            if (prev_start2) chk("start_width", 32'(start2), 0);
            prev_start2 = start2;
            if (a_we2) ev(2, 0, int'(a_i2), int'(a_j2), a_in2);
            if (b_we2) begin
                ev(2, 1, int'(b_i2), int'(b_j2), b_in2);
                last_b_cyc2 = cyc2;
            end
            if (start2) begin
                ev(2, 2, 0, 0, 0);
                chk("start_gap", cyc2 - last_b_cyc2, 1);
            end
            if (a_we3)  ev(3, 0, int'(a_i3), int'(a_j3), a_in3);
            if (b_we3)  ev(3, 1, int'(b_i3), int'(b_j3), b_in3);
            if (start3) ev(3, 2, 0, 0, 0);
        end
    end

    task automatic push(input int inst, input int kind, input int i, input int j, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.i = i; e.j = j; e.d = d;
        if (inst == 2) q2.push_back(e);
        else           q3.push_back(e);
    endtask

    task automatic send(input int inst, input logic [31:0] data, input logic last,
                        input int kind, input int i, input int j);
        int waitc;
        @(negedge clk);
        s_data  = data;
        s_valid = 1'b1;
        s_last  = last;
        push(inst, kind, i, j, data);
        waitc = 0;
        while (!((inst == 2) ? s_ready2 : s_ready3) && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout inst%0d: s_ready got 0, required 1", inst);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // One full n=2 run: 4 A words then 4 B words, followed by the start pulse.
    task automatic run2(input logic [31:0] base, input int gap_after, input int last_at,
                        input int err_word, input int hold, input logic exp_err);
        for (int k = 0; k < 8; k++) begin
            if (k == err_word) chk("err_before", 32'(err2), 0);
            send(2, base + 32'(k), (k == last_at), (k < 4) ? 0 : 1, (k % 4) / 2, k % 2);
            if (k == err_word) chk("err_after", 32'(err2), 1);
            if (k == gap_after) begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    chk("gap_a_we", 32'(a_we2), 0);
                    chk("gap_a_i", 32'(a_i2), 0);
                    chk("gap_a_j", 32'(a_j2), 1);
                end
            end
        end
        push(2, 2, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_busy", 32'(busy2), 1);
            chk("hold_ready", 32'(s_ready2), 0);
        end
        chk("err_run", 32'(err2), 32'(exp_err));
    endtask

    task automatic release_done(input int low);
        @(negedge clk);
        done = 1'b0;
        for (int c = 0; c < low; c++) begin
            @(negedge clk);
            chk("wait_busy", 32'(busy2), 1);
            chk("wait_ready", 32'(s_ready2), 0);
        end
        done = 1'b1;
        chk("edge_ready", 32'(s_ready2), 0);
        @(negedge clk);
        chk("release_ready", 32'(s_ready2), 1);
        chk("release_busy", 32'(busy2), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst2 = 1'b1;
        #1;
        chk("rst_ready", 32'(s_ready2), 1);
        chk("rst_a_we", 32'(a_we2), 0);
        chk("rst_b_we", 32'(b_we2), 0);
        chk("rst_start", 32'(start2), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_err", 32'(err2), 0);
        chk("rst_idx", {28'd0, a_i2, a_j2, b_i2, b_j2}, 0);

        run2(32'd1,  -1, 7, -1, 2, 1'b0);   // plain run, words 1..8
        release_done(1);
        run2(32'd11,  1, 7, -1, 6, 1'b0);   // back-pressure, done left high
        release_done(10);
        run2(32'd21, -1, 2,  2, 3, 1'b1);   // s_last on word 3
        release_done(2);

        @(negedge clk); rst2 = 1'b0;
        @(negedge clk); rst2 = 1'b1;
        #1;
        chk("rerst_err", 32'(err2), 0);
        run2(32'd31, -1, -1, 7, 2, 1'b1);   // s_last missing on B(1,1)
        release_done(1);

        // n=3: reset in the middle of loading B.
        @(negedge clk); rst2 = 1'b0;
        @(negedge clk); rst3 = 1'b1;
        #1;
        chk("rst3_ready", 32'(s_ready3), 1);
        for (int k = 0; k < 12; k++) begin
            send(3, 32'h100 + 32'(k), 1'b0, (k < 9) ? 0 : 1, (k % 9) / 3, k % 3);
        end
        @(negedge clk);
        #1;
        chk("pre_b_we3", 32'(b_we3), 1);
        chk("pre_b_j3", 32'(b_j3), 2);
        rst3 = 1'b0;
        #1;
        chk("mid_b_we3", 32'(b_we3), 0);
        chk("mid_b_in3", b_in3, 0);
        chk("mid_a_in3", a_in3, 0);
        chk("mid_idx3", {24'd0, a_i3, a_j3, b_i3, b_j3}, 0);
        chk("mid_ready3", 32'(s_ready3), 0);
        chk("mid_flags3", {29'd0, busy3, err3, start3}, 0);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        chk("post_ready3", 32'(s_ready3), 1);
        send(3, 32'h99, 1'b0, 0, 0, 0);

        for (int c = 0; c < 20 && (q2.size() + q3.size()) != 0; c++) @(negedge clk);
        chk("queue_drain", q2.size() + q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
